// File: rtl/serializer_pkg.sv
// Shared constants and elaboration helpers for the TMDS serializer gearbox.
//   TMDS_CTRL     : the four TMDS control symbols, indexed by {C1,C0}; entry 0 is the idle symbol
//   slices()      : number of B-bit slices per W-bit word
//   clock_pattern : pixel-clock lane word (first-transmitted half ones, second half zeros)
package serializer_pkg;

    localparam int unsigned TMDS_W = 10;

    localparam logic [TMDS_W-1:0] TMDS_CTRL [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    function automatic int unsigned slices(input int unsigned w, input int unsigned b);
        return w / b;
    endfunction

    // Ones occupy whichever half of the word leaves the shifter first.
    function automatic logic [63:0] clock_pattern(input int unsigned w, input bit lsb_first);
        logic [63:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < w / 2; i++) begin
            if (lsb_first) pat[6'(i)] = 1'b1;
            else           pat[6'(w - 1 - i)] = 1'b1;
        end
        return pat;
    endfunction

endpackage

// File: rtl/serializer_fifo.sv
// Single-clock FIFO with a combinational head read.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : write request (ignored when full)
//   pop, pop_data       : read request (ignored when empty), head word
//   full, empty, level  : occupancy status
module serializer_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [DATA_WIDTH-1:0]          push_data,
    input  logic                           pop,
    output logic [DATA_WIDTH-1:0]          pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  w_push;
    logic                  w_pop;

    assign full     = (r_level == LW'(DEPTH));
    assign empty    = (r_level == '0);
    assign level    = r_level;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;

    // Storage needs no reset; validity is tracked by the level counter.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/tmds_serializer_gearbox.sv
// Bit-clock-domain TMDS serializer: valid/ready input FIFO feeding a W-to-B gearbox,
// with a generated pixel-clock lane, idle insertion and underflow accounting.
//   clk_pixel_x5, reset_n       : bit clock, asynchronous active-low reset
//   enable                      : 0 forces idle words at word boundaries and holds the FIFO
//   in_valid, in_ready, in_data : symbol-word input handshake (channel i at [i*W +: W])
//   out_lanes, out_clock_lane   : B bits per lane per cycle, bit 0 earliest in time
//   word_start                  : slice 0 of a new word is on the lanes
//   underflow, underflow_count  : idle inserted for lack of data, saturating count
//   fifo_level                  : FIFO occupancy
module tmds_serializer_gearbox
    import serializer_pkg::*;
#(
    parameter int unsigned           NUM_CHANNELS    = 3,
    parameter int unsigned           WORD_WIDTH      = 10,
    parameter int unsigned           BITS_PER_CYCLE  = 2,
    parameter bit                    LSB_FIRST       = 1'b1,
    parameter int unsigned           FIFO_DEPTH      = 2,
    parameter logic [WORD_WIDTH-1:0] IDLE_WORD       = WORD_WIDTH'(TMDS_CTRL[0]),
    parameter int unsigned           UNDERFLOW_WIDTH = 16
) (
    input  logic                                    clk_pixel_x5,
    input  logic                                    reset_n,
    input  logic                                    enable,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [NUM_CHANNELS*WORD_WIDTH-1:0]      in_data,
    output logic [NUM_CHANNELS*BITS_PER_CYCLE-1:0]  out_lanes,
    output logic [BITS_PER_CYCLE-1:0]               out_clock_lane,
    output logic                                    word_start,
    output logic                                    underflow,
    output logic [UNDERFLOW_WIDTH-1:0]              underflow_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]         fifo_level
);

    localparam int unsigned W      = WORD_WIDTH;
    localparam int unsigned B      = BITS_PER_CYCLE;
    localparam int unsigned NW     = NUM_CHANNELS * W;
    localparam int unsigned SLICES = slices(W, B);
    localparam int unsigned PW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [W-1:0] CLK_PATTERN = W'(clock_pattern(W, LSB_FIRST));

    generate
        if ((W % B) != 0) begin : g_bad_width
            $error("WORD_WIDTH must be a multiple of BITS_PER_CYCLE");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [PW-1:0]              r_phase;
    logic [NW-1:0]              r_sr;
    logic [W-1:0]               r_clk_sr;
    logic                       r_word_start;
    logic                       r_underflow;
    logic [UNDERFLOW_WIDTH-1:0] r_uf_count;

    logic                       w_load;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_underflow;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [NW-1:0]              w_head;
    logic [NW-1:0]              w_sr_next;
    logic [W-1:0]               w_clk_next;

    serializer_fifo #(
        .DATA_WIDTH (NW),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_pixel_x5),
        .rst_n      (reset_n),
        .push       (w_push),
        .push_data  (in_data),
        .pop        (w_pop),
        .pop_data   (w_head),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty),
        .level      (fifo_level)
    );

    // Load-edge source selection: FIFO head, or idle (underflow only when enabled).
    always_comb begin
        w_load      = (r_phase == PW'(SLICES - 1));
        w_push      = in_valid && !w_fifo_full;
        w_pop       = w_load && enable && !w_fifo_empty;
        w_underflow = w_load && enable && w_fifo_empty;
    end

    // Gearbox: reload at the load edge, otherwise drain B bits toward the output end.
    always_comb begin
        w_sr_next  = r_sr;
        w_clk_next = r_clk_sr;
        if (w_load) begin
            w_sr_next  = w_pop ? w_head : {NUM_CHANNELS{IDLE_WORD}};
            w_clk_next = CLK_PATTERN;
        end else if (LSB_FIRST) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                w_sr_next[ch*W +: W] = r_sr[ch*W +: W] >> B;
            end
            w_clk_next = r_clk_sr >> B;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                w_sr_next[ch*W +: W] = r_sr[ch*W +: W] << B;
            end
            w_clk_next = r_clk_sr << B;
        end
    end

    // Phase resets to the last slice so the first edge after reset is a load edge.
    always_ff @(posedge clk_pixel_x5 or negedge reset_n) begin
        if (!reset_n) begin
            r_phase      <= PW'(SLICES - 1);
            r_sr         <= '0;
            r_clk_sr     <= '0;
            r_word_start <= 1'b0;
            r_underflow  <= 1'b0;
            r_uf_count   <= '0;
        end else begin
            r_phase      <= w_load ? '0 : r_phase + PW'(1);
            r_sr         <= w_sr_next;
            r_clk_sr     <= w_clk_next;
            r_word_start <= w_load;
            r_underflow  <= w_underflow;
            if (w_underflow && (r_uf_count != '1)) begin
                r_uf_count <= r_uf_count + UNDERFLOW_WIDTH'(1);
            end
        end
    end

    // Output slices come straight from the shifter's output end.
    always_comb begin
        out_lanes      = '0;
        out_clock_lane = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            for (int k = 0; k < B; k++) begin
                out_lanes[ch*B + k] = LSB_FIRST ? r_sr[ch*W + k] : r_sr[ch*W + W - 1 - k];
            end
        end
        for (int k = 0; k < B; k++) begin
            out_clock_lane[k] = LSB_FIRST ? r_clk_sr[k] : r_clk_sr[W - 1 - k];
        end
    end

    assign in_ready        = !w_fifo_full;
    assign word_start      = r_word_start;
    assign underflow       = r_underflow;
    assign underflow_count = r_uf_count;

endmodule

// File: tb/tb_tmds_serializer_gearbox.sv
// Self-checking bench: default (A), MSB-first (B) and 4-bit-counter (C) instances.
module tb_tmds_serializer_gearbox;

    localparam int NC = 3;
    localparam int W  = 10;
    localparam int B  = 2;
    localparam int S  = 5;
    localparam logic [9:0] IDLE = 10'b1101010100;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] idle_pat [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    logic [1:0] clk_pat  [5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    logic [1:0] msb_pat  [5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};

    // Instance A: defaults
    logic        rst_n, enable, in_valid, in_ready, word_start, underflow;
    logic [29:0] in_data;
    logic [5:0]  out_lanes;
    logic [1:0]  out_clock_lane, fifo_level;
    logic [15:0] underflow_count;

    // Instance B: MSB first
    logic        rst_n_b, enable_b, in_valid_b, in_ready_b, word_start_b, underflow_b;
    logic [29:0] in_data_b;
    logic [5:0]  out_lanes_b;
    logic [1:0]  out_clock_lane_b, fifo_level_b;
    logic [15:0] underflow_count_b;

    // Instance C: 4-bit underflow counter
    logic        rst_n_c, enable_c, in_valid_c, in_ready_c, word_start_c, underflow_c;
    logic [29:0] in_data_c;
    logic [5:0]  out_lanes_c;
    logic [1:0]  out_clock_lane_c, fifo_level_c;
    logic [3:0]  underflow_count_c;

    tmds_serializer_gearbox dut_a (
        .clk_pixel_x5(clk), .reset_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_lanes(out_lanes),
        .out_clock_lane(out_clock_lane), .word_start(word_start), .underflow(underflow),
        .underflow_count(underflow_count), .fifo_level(fifo_level)
    );

    tmds_serializer_gearbox #(.LSB_FIRST(1'b0)) dut_b (
        .clk_pixel_x5(clk), .reset_n(rst_n_b), .enable(enable_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_data(in_data_b), .out_lanes(out_lanes_b),
        .out_clock_lane(out_clock_lane_b), .word_start(word_start_b), .underflow(underflow_b),
        .underflow_count(underflow_count_b), .fifo_level(fifo_level_b)
    );

    tmds_serializer_gearbox #(.UNDERFLOW_WIDTH(4)) dut_c (
        .clk_pixel_x5(clk), .reset_n(rst_n_c), .enable(enable_c), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .in_data(in_data_c), .out_lanes(out_lanes_c),
        .out_clock_lane(out_clock_lane_c), .word_start(word_start_c), .underflow(underflow_c),
        .underflow_count(underflow_count_c), .fifo_level(fifo_level_c)
    );

    // Scoreboard for instance A: words pushed are expected back in order.
    logic [29:0] exp_q [$];
    int          rx_idx [$];

    int          mon_idx = -1;
    int          mon_count = 0;
    logic [29:0] mon_word;
    logic [29:0] mon_exp;
    logic        mon_uf;

    // Deserialise instance A lanes (LSB first) and score every non-idle word.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mon_idx = -1;
        end else begin
            if (word_start === 1'b1) begin
                mon_idx  = 0;
                mon_uf   = underflow;
                mon_word = '0;
            end
            if (mon_idx >= 0) begin
                for (int ch = 0; ch < NC; ch++)
                    for (int k = 0; k < B; k++)
                        mon_word[ch*W + mon_idx*B + k] = out_lanes[ch*B + k];
                mon_idx++;
                if (mon_idx == S) begin
                    if (mon_word !== {3{IDLE}}) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_unexpected got %h expected none", mon_word);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            if (mon_word !== mon_exp) begin
                                n_fail++;
                                $display("FAIL sb_word got %h expected %h", mon_word, mon_exp);
                            end
                        end
                        n_checks++;
                        if (mon_uf !== 1'b0) begin
                            n_fail++;
                            $display("FAIL sb_underflow_on_data got %b expected 0", mon_uf);
                        end
                        rx_idx.push_back(mon_count);
                    end
                    mon_count++;
                    mon_idx = -1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [29:0] w);
        int budget = 0;
        bit done   = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        while (!done && budget < 50) begin
            done = in_ready;
            tick();
            budget++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL push_timeout got ready=0 expected ready=1 within 50 cycles");
        end else begin
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout got %0d pending expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) tick();
        n_checks += 7;
        if (out_lanes !== 6'd0)        begin n_fail++; $display("FAIL rst_lanes got %b expected 0", out_lanes); end
        if (out_clock_lane !== 2'd0)   begin n_fail++; $display("FAIL rst_clock got %b expected 0", out_clock_lane); end
        if (word_start !== 1'b0)       begin n_fail++; $display("FAIL rst_word_start got %b expected 0", word_start); end
        if (underflow !== 1'b0)        begin n_fail++; $display("FAIL rst_underflow got %b expected 0", underflow); end
        if (underflow_count !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d expected 0", underflow_count); end
        if (fifo_level !== 2'd0)       begin n_fail++; $display("FAIL rst_level got %0d expected 0", fifo_level); end
        if (in_ready !== 1'b1)         begin n_fail++; $display("FAIL rst_ready got %b expected 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks += 5;
            if (out_lanes !== {3{idle_pat[c%5]}}) begin
                n_fail++; $display("FAIL idle_lanes c=%0d got %b expected %b", c, out_lanes, {3{idle_pat[c%5]}});
            end
            if (out_clock_lane !== clk_pat[c%5]) begin
                n_fail++; $display("FAIL idle_clock c=%0d got %b expected %b", c, out_clock_lane, clk_pat[c%5]);
            end
            if (word_start !== (c % 5 == 0)) begin
                n_fail++; $display("FAIL idle_word_start c=%0d got %b", c, word_start);
            end
            if (underflow !== (c % 5 == 0)) begin
                n_fail++; $display("FAIL idle_underflow c=%0d got %b", c, underflow);
            end
            if (underflow_count !== 16'(c / 5 + 1)) begin
                n_fail++; $display("FAIL idle_count c=%0d got %0d expected %0d", c, underflow_count, c / 5 + 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [29:0] w;
        w = {10'h155, 10'h000, 10'h3FF};
        rx_idx.delete();
        push_a(w);
        push_a(w);
        n_checks += 2;
        if (fifo_level !== 2'd2) begin n_fail++; $display("FAIL b2b_level got %0d expected 2", fifo_level); end
        if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL b2b_ready got %b expected 0", in_ready); end
        push_a(w);
        wait_drain(60, "b2b");
        n_checks++;
        if (rx_idx.size() != 3) begin
            n_fail++; $display("FAIL b2b_count got %0d expected 3", rx_idx.size());
        end else begin
            n_checks += 2;
            if (rx_idx[1] - rx_idx[0] != 1) begin n_fail++; $display("FAIL b2b_gap1 got %0d expected 1", rx_idx[1] - rx_idx[0]); end
            if (rx_idx[2] - rx_idx[1] != 1) begin n_fail++; $display("FAIL b2b_gap2 got %0d expected 1", rx_idx[2] - rx_idx[1]); end
        end
    endtask

    task automatic test_enable_gate;
        enable = 1'b0;
        push_a({10'h0F0, 10'h30F, 10'h1E1});
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks += 2;
            if (fifo_level !== 2'd1) begin n_fail++; $display("FAIL gate_level c=%0d got %0d expected 1", c, fifo_level); end
            if (underflow !== 1'b0)  begin n_fail++; $display("FAIL gate_underflow c=%0d got %b expected 0", c, underflow); end
        end
        n_checks++;
        if (exp_q.size() != 1) begin n_fail++; $display("FAIL gate_held got %0d pending expected 1", exp_q.size()); end
        enable = 1'b1;
        wait_drain(12, "gate_release");
    endtask

    task automatic test_async_reset;
        int t = 0;
        push_a({10'h111, 10'h222, 10'h2A6});
        push_a({10'h333, 10'h0AA, 10'h155});
        while (!(word_start === 1'b1 && out_lanes[1:0] === 2'b10) && t < 30) begin
            tick();
            t++;
        end
        n_checks++;
        if (t >= 30) begin n_fail++; $display("FAIL arst_start_timeout got none expected word_start"); end
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks += 7;
        if (out_lanes !== 6'd0)        begin n_fail++; $display("FAIL arst_lanes got %b expected 0", out_lanes); end
        if (out_clock_lane !== 2'd0)   begin n_fail++; $display("FAIL arst_clock got %b expected 0", out_clock_lane); end
        if (word_start !== 1'b0)       begin n_fail++; $display("FAIL arst_word_start got %b expected 0", word_start); end
        if (underflow !== 1'b0)        begin n_fail++; $display("FAIL arst_underflow got %b expected 0", underflow); end
        if (underflow_count !== 16'd0) begin n_fail++; $display("FAIL arst_count got %0d expected 0", underflow_count); end
        if (fifo_level !== 2'd0)       begin n_fail++; $display("FAIL arst_level got %0d expected 0", fifo_level); end
        if (in_ready !== 1'b1)         begin n_fail++; $display("FAIL arst_ready got %b expected 1", in_ready); end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (word_start !== 1'b0) begin n_fail++; $display("FAIL arst_release_ws got %b expected 0", word_start); end
        tick();
        n_checks += 5;
        if (word_start !== 1'b1)       begin n_fail++; $display("FAIL arst_first_ws got %b expected 1", word_start); end
        if (out_lanes !== 6'b000000)   begin n_fail++; $display("FAIL arst_first_lanes got %b expected 000000", out_lanes); end
        if (out_clock_lane !== 2'b11)  begin n_fail++; $display("FAIL arst_first_clock got %b expected 11", out_clock_lane); end
        if (underflow !== 1'b1)        begin n_fail++; $display("FAIL arst_first_uf got %b expected 1", underflow); end
        if (underflow_count !== 16'd1) begin n_fail++; $display("FAIL arst_first_count got %0d expected 1", underflow_count); end
    endtask

    task automatic test_msb_first;
        tick();
        n_checks++;
        if (out_lanes_b !== 6'd0) begin n_fail++; $display("FAIL msb_rst_lanes got %b expected 0", out_lanes_b); end
        rst_n_b    = 1'b1;
        in_valid_b = 1'b1;
        in_data_b  = {20'h0, 10'b1000000001};
        tick();
        in_valid_b = 1'b0;
        n_checks += 3;
        if (word_start_b !== 1'b1)       begin n_fail++; $display("FAIL msb_idle_ws got %b expected 1", word_start_b); end
        if (out_lanes_b[1:0] !== 2'b11)  begin n_fail++; $display("FAIL msb_idle_slice got %b expected 11", out_lanes_b[1:0]); end
        if (fifo_level_b !== 2'd1)       begin n_fail++; $display("FAIL msb_level got %0d expected 1", fifo_level_b); end
        repeat (5) tick();
        for (int s = 0; s < S; s++) begin
            if (s > 0) tick();
            n_checks += 4;
            if (out_lanes_b[1:0] !== msb_pat[s]) begin
                n_fail++; $display("FAIL msb_ch0 s=%0d got %b expected %b", s, out_lanes_b[1:0], msb_pat[s]);
            end
            if (out_lanes_b[5:2] !== 4'b0000) begin
                n_fail++; $display("FAIL msb_ch12 s=%0d got %b expected 0000", s, out_lanes_b[5:2]);
            end
            if (out_clock_lane_b !== clk_pat[s]) begin
                n_fail++; $display("FAIL msb_clock s=%0d got %b expected %b", s, out_clock_lane_b, clk_pat[s]);
            end
            if (word_start_b !== (s == 0)) begin
                n_fail++; $display("FAIL msb_ws s=%0d got %b", s, word_start_b);
            end
        end
    endtask

    task automatic test_underflow_saturate;
        int e;
        tick();
        rst_n_c = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            n_checks++;
            if (underflow_c !== (c % 5 == 0)) begin
                n_fail++; $display("FAIL sat_pulse c=%0d got %b", c, underflow_c);
            end
            if (c % 5 == 0) begin
                e = c / 5 + 1;
                if (e > 15) e = 15;
                n_checks++;
                if (underflow_count_c !== 4'(e)) begin
                    n_fail++; $display("FAIL sat_count c=%0d got %0d expected %0d", c, underflow_count_c, e);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;  enable = 1'b1;   in_valid = 1'b0;   in_data = '0;
        rst_n_b = 1'b0; enable_b = 1'b1; in_valid_b = 1'b0; in_data_b = '0;
        rst_n_c = 1'b0; enable_c = 1'b1; in_valid_c = 1'b0; in_data_c = '0;
        test_reset();
        test_idle();
        test_back_to_back();
        test_enable_gate();
        test_async_reset();
        test_msb_first();
        test_underflow_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
